// File: rtl/sl3_fec_pkg.sv
// rtl/sl3_fec_pkg.sv - shared types and width helpers for the SL3 FEC receive path
package sl3_fec_pkg;

    // Lane lock state; HUNT is the reset state.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam int DEF_LOCK_GOOD  = 8;
    localparam int DEF_UNLOCK_BAD = 4;
    localparam int DEF_WINDOW     = 64;

    // Bits needed to hold a counter that must reach max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    localparam int DEF_GOOD_RUN_W = cnt_width(DEF_LOCK_GOOD);
    localparam int DEF_BAD_W      = cnt_width(DEF_UNLOCK_BAD);
    localparam int DEF_WIN_W      = cnt_width(DEF_WINDOW);

endpackage

// File: rtl/xor_2tick.sv
// rtl/xor_2tick.sv - two-level registered XOR reduction, up to 36 inputs
//
// Ports:
//   clk  in  1  clock
//   d    in  N  vector to reduce
//   q    out 1  XOR of d, two clock edges after d is sampled
// The registers carry no reset; callers qualify q with their own valid pipeline.
module xor_2tick #(
    parameter int N           = 33,
    parameter int TARGET_CHIP = 2
) (
    input  logic         clk,
    input  logic [N-1:0] d,
    output logic         q
);

    // First-level group size follows the LUT width of the target fabric.
    localparam int GRP = (TARGET_CHIP == 2) ? 6 : 4;
    localparam int NG  = 36 / GRP;

    logic [35:0]   padded;
    logic [NG-1:0] part;

    // Zero padding leaves the parity of d unchanged.
    assign padded = 36'(d);

    always_ff @(posedge clk) begin
        for (int g = 0; g < NG; g++) begin
            part[g] <= ^padded[g*GRP +: GRP];
        end
        q <= ^part;
    end

endmodule

// File: rtl/parity_lane_monitor.sv
// rtl/parity_lane_monitor.sv - lane parity checker with lock FSM and error statistics
//
// Ports:
//   clk        in  1          clock
//   arst_n     in  1          asynchronous active-low reset
//   din_valid  in  1          din/din_par meaningful this cycle
//   din        in  WIDTH      data word
//   din_par    in  1          transmitted even parity of din
//   clr_stats  in  1          synchronous clear of err_cnt and err_seen
//   par_valid  out 1          result strobe, 3 cycles after din_valid
//   par_err    out 1          parity error, qualified by par_valid
//   locked     out 1          lock FSM is in LOCKED
//   err_seen   out 1          sticky error flag
//   err_cnt    out CNT_WIDTH  saturating parity error count
module parity_lane_monitor
    import sl3_fec_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LOCK_GOOD   = 8,
    parameter int UNLOCK_BAD  = 4,
    parameter int WINDOW      = 64,
    parameter int CNT_WIDTH   = 16,
    parameter int TARGET_CHIP = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 din_valid,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_par,
    input  logic                 clr_stats,
    output logic                 par_valid,
    output logic                 par_err,
    output logic                 locked,
    output logic                 err_seen,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int GR_W  = cnt_width(LOCK_GOOD);
    localparam int BAD_W = cnt_width(UNLOCK_BAD);
    localparam int WIN_W = cnt_width(WINDOW);

    localparam logic [GR_W-1:0]  LOCK_GOOD_C  = GR_W'(LOCK_GOOD);
    localparam logic [BAD_W-1:0] UNLOCK_BAD_C = BAD_W'(UNLOCK_BAD);
    localparam logic [WIN_W-1:0] WINDOW_C     = WIN_W'(WINDOW);

    if (WIDTH > 35 || LOCK_GOOD == 0 || UNLOCK_BAD == 0 || WINDOW == 0) begin : g_param_check
        $error("parity_lane_monitor: illegal WIDTH/LOCK_GOOD/UNLOCK_BAD/WINDOW");
    end

    logic red;

    xor_2tick #(
        .N           (WIDTH + 1),
        .TARGET_CHIP (TARGET_CHIP)
    ) u_xor (
        .clk (clk),
        .d   ({din_par, din}),
        .q   (red)
    );

    // Valid travels alongside the two reduction registers; it masks the
    // unreset reduction contents after reset and drops in-flight words.
    logic [1:0] vpipe;
    logic       w_valid;
    logic       w_err;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) vpipe <= '0;
        else         vpipe <= {vpipe[0], din_valid};
    end

    assign w_valid = vpipe[1];
    assign w_err   = vpipe[1] & red;

    lock_state_t      state, state_n;
    logic [GR_W-1:0]  good_run, good_run_n, good_inc;
    logic [WIN_W-1:0] win_cnt, win_n, win_inc;
    logic [BAD_W-1:0] bad_cnt, bad_n, bad_inc;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= HUNT;
            good_run <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_n;
            good_run <= good_run_n;
            win_cnt  <= win_n;
            bad_cnt  <= bad_n;
        end
    end

    always_comb begin
        state_n    = state;
        good_run_n = good_run;
        win_n      = win_cnt;
        bad_n      = bad_cnt;
        good_inc   = good_run + 1'b1;
        win_inc    = win_cnt + 1'b1;
        bad_inc    = bad_cnt + BAD_W'(w_err);
        if (w_valid) begin
            case (state)
                HUNT: begin
                    if (w_err) begin
                        good_run_n = '0;
                    end else if (good_inc == LOCK_GOOD_C) begin
                        state_n    = LOCKED;
                        good_run_n = '0;
                        win_n      = '0;
                        bad_n      = '0;
                    end else begin
                        good_run_n = good_inc;
                    end
                end
                LOCKED: begin
                    // Unlock is tested before window rollover so it wins a tie.
                    if (bad_inc == UNLOCK_BAD_C) begin
                        state_n    = HUNT;
                        good_run_n = '0;
                        win_n      = '0;
                        bad_n      = '0;
                    end else if (win_inc == WINDOW_C) begin
                        win_n = '0;
                        bad_n = '0;
                    end else begin
                        win_n = win_inc;
                        bad_n = bad_inc;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    logic [CNT_WIDTH-1:0] err_cnt_n;
    logic                 err_seen_n;

    // Clear is applied first so a coincident error is still counted.
    always_comb begin
        err_cnt_n  = err_cnt;
        err_seen_n = err_seen;
        if (clr_stats) begin
            err_cnt_n  = '0;
            err_seen_n = 1'b0;
        end
        if (w_err) begin
            err_seen_n = 1'b1;
            if (err_cnt_n != '1) err_cnt_n = err_cnt_n + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            par_valid <= 1'b0;
            par_err   <= 1'b0;
            err_cnt   <= '0;
            err_seen  <= 1'b0;
        end else begin
            par_valid <= w_valid;
            par_err   <= w_err;
            err_cnt   <= err_cnt_n;
            err_seen  <= err_seen_n;
        end
    end

    assign locked = (state == LOCKED);

endmodule
